utopia_phy_tx: RTL
==================

Name: utopia_phy_tx

Overview:
- PHY-side cell source for the Utopia receive path: buffers complete ATM cells and presents them to an ATM-layer receiver on data/soc/clav.
- Paced by the receiver's active-low en.
- Serves as the far end of the receive modport in system benches, and as the PHY stub in loopback builds.
- The local side loads cells byte-serially; the Utopia side streams 53-byte cells with soc on byte 0.

Parameters:
- IfWidth, 8, Utopia data width; only 8 is supported, so each cell is 53 transfers.
- DEPTH, 2, cell buffer capacity in whole cells (power of 2, ≥2).
- CELL_BYTES, 53, bytes per cell (UNI format: header bytes 0-3, HEC byte 4, payload 5-52).

Ports:
- clk_in  input  1  Utopia clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
- wr_valid  input  1  load byte valid.
- wr_sop  input  1  load byte is byte 0 of a cell.
- wr_data  input  IfWidth  load byte.
- wr_ready  output  1  buffer can accept a byte this cycle.
- en  input  1  active-low read enable from ATM-layer receiver.
- data  output  IfWidth  Utopia cell byte.
- soc  output  1  start of cell, high with byte 0.
- clav  output  1  complete cell available.
- cell_sent  output  1  one-cycle pulse when last byte of a cell is consumed.
- err_drop  output  1  one-cycle pulse when a load byte/partial cell is discarded.

Behaviour:
- Clocking/reset: one clock (clk_in); reset is asynchronous and active-high.
- Reset values: data=0, soc=0, clav=0, wr_ready=1, cell_sent=0, err_drop=0. All pointers, counts and the FSM return to zero/IDLE. A partial load or in-flight cell is abandoned.
- Storage: DEPTH×53-byte RAM with write-cell pointer, read-cell pointer and count (0..DEPTH) of committed cells.

Write side:
- wr_ready is registered and equals (count < DEPTH) after the next-state update.
- A byte transfers when wr_valid && wr_ready.
- A byte with wr_sop goes to offset 0. If a partial cell is in progress, it is discarded and err_drop pulses.
- A byte without wr_sop while no cell is in progress is dropped and err_drop pulses.
- The cell commits when offset 52 is written; count increments on the following edge.

Transmit FSM, states IDLE and SEND:
- clav is registered high when count minus (1 if SEND) is ≥1.
- IDLE:
  - On an edge with en=0 and clav=1: drive byte 0, soc=1, go to SEND with idx=1.
  - Otherwise data/soc hold; soc=0.
- SEND, edge with en=0 and idx≤52: drive byte idx, soc=0, idx++.
- SEND, edge with en=1: hold data, soc=0 (pause, unbounded).
- SEND, edge with en=0 and idx=53 (byte 52 already driven):
  - Release the cell: read pointer advances, count decrements, cell_sent pulses.
  - If another committed cell exists, drive its byte 0 with soc=1 (back-to-back, no gap) and stay in SEND.
  - Otherwise go to IDLE.
- Latency: byte 0 appears on data one edge after en is sampled low with clav=1.

Boundaries:
- Commit and release on the same edge: count is unchanged; clav stays correct.
- Full (count=DEPTH): wr_ready=0; a load byte presented then is not accepted (no drop).
- Pointers wrap modulo DEPTH.
- clav never covers the cell currently in flight.
- en toggling in IDLE with clav=0 has no effect.

Optional Feature:
- Macro UTOPIA_HEC_GEN_EN.
- Defined: the write side computes CRC-8 (x^8+x^2+x+1, init 0) over header bytes 0-3 and stores CRC XOR 0x55 at offset 4, ignoring the loaded byte 4.
- Undefined: byte 4 is stored as loaded. No CRC logic is present.

Test Plan:
- Reset, load one cell of bytes 0x00..0x34, hold en=0 → clav=1 two edges after commit; data=0x00 with soc=1, then 0x01..0x34 on consecutive edges; cell_sent pulses once; clav=0 afterward.
- Load 2 cells, en=0 continuously → 106 consecutive bytes; soc high on transfers 0 and 53 only; two cell_sent pulses; no idle cycle between cells.
- Mid-cell, raise en for 5 cycles at idx=20 → data holds byte 19 for 5 cycles, then resumes with 20; total cell bytes are still 53 and in order.
- Fill DEPTH=2 cells with en=1 → wr_ready=0, the third cell's byte is not accepted; after one cell is sent, wr_ready=1 and the third cell loads and is transmitted.
- Load 10 bytes, then a new wr_sop → err_drop pulses once; only the second cell is transmitted. A stray byte without wr_sop in idle → err_drop pulse, clav stays 0.
- With UTOPIA_HEC_GEN_EN, header 0x00 0x00 0x00 0x01 with byte 4 loaded as 0xFF → transmitted byte 4 = 0x52. Without the macro → 0xFF.

Source files
------------

// File: rtl/utopia_phy_tx.sv
// PHY-side Utopia cell source: buffers whole 53-byte cells loaded byte-serially and streams them
// to an ATM-layer receiver paced by active-low en. Define UTOPIA_HEC_GEN_EN to generate the HEC byte.
module utopia_phy_tx #(
  parameter int IfWidth    = 8,
  parameter int DEPTH      = 2,
  parameter int CELL_BYTES = 53
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic               wr_sop,
  input  logic [IfWidth-1:0] wr_data,
  output logic               wr_ready,
  input  logic               en,
  output logic [IfWidth-1:0] data,
  output logic               soc,
  output logic               clav,
  output logic               cell_sent,
  output logic               err_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OFF_W = $clog2(CELL_BYTES + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH * CELL_BYTES);
  localparam logic [OFF_W-1:0] LAST = OFF_W'(CELL_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [IfWidth-1:0] mem [DEPTH*CELL_BYTES];

  // Write-side state
  logic             in_prog_q, in_prog_d;
  logic [OFF_W-1:0] wr_off_q, wr_off_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             commit_q, commit_d;
  logic             err_drop_q, err_drop_d;
  logic             wr_ready_q, wr_ready_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [IfWidth-1:0] mem_wdata;

  // Transmit-side state
  state_t             state_q, state_d;
  logic [OFF_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IfWidth-1:0] data_q, data_d;
  logic               soc_q, soc_d;
  logic               clav_q, clav_d;
  logic               cell_sent_q, cell_sent_d;
  logic               release_cell;

`ifdef UTOPIA_HEC_GEN_EN
  localparam logic [OFF_W-1:0] HEC_OFF = OFF_W'(4);
  logic [7:0] crc_q, crc_d;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  function automatic logic [AW-1:0] cell_addr(input logic [PTR_W-1:0] ptr,
                                              input logic [OFF_W-1:0] off);
    return AW'(ptr) * AW'(CELL_BYTES) + AW'(off);
  endfunction

  // Loader: a sop byte always restarts at offset 0; body bytes need a cell in progress.
  always_comb begin
    in_prog_d  = in_prog_q;
    wr_off_d   = wr_off_q;
    wr_ptr_d   = wr_ptr_q;
    commit_d   = 1'b0;
    err_drop_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cell_addr(wr_ptr_q, wr_off_q);
    mem_wdata  = wr_data;
`ifdef UTOPIA_HEC_GEN_EN
    crc_d      = crc_q;
`endif
    if (wr_valid && wr_ready_q) begin
      if (wr_sop) begin
        err_drop_d = in_prog_q;
        mem_we     = 1'b1;
        mem_waddr  = cell_addr(wr_ptr_q, OFF_W'(0));
        in_prog_d  = 1'b1;
        wr_off_d   = OFF_W'(1);
`ifdef UTOPIA_HEC_GEN_EN
        crc_d      = crc8_step(8'h00, wr_data);
`endif
      end else if (!in_prog_q) begin
        err_drop_d = 1'b1;
      end else begin
        mem_we = 1'b1;
`ifdef UTOPIA_HEC_GEN_EN
        if (wr_off_q == HEC_OFF) begin
          mem_wdata = crc_q ^ 8'h55;
        end else if (wr_off_q < HEC_OFF) begin
          crc_d = crc8_step(crc_q, wr_data);
        end
`endif
        if (wr_off_q == LAST) begin
          commit_d  = 1'b1;
          in_prog_d = 1'b0;
          wr_off_d  = OFF_W'(0);
          wr_ptr_d  = wr_ptr_q + 1'b1;
        end else begin
          wr_off_d = wr_off_q + 1'b1;
        end
      end
    end
  end

  // Transmit FSM next state; the last byte's edge also launches byte 0 of the next cell.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_ptr_d     = rd_ptr_q;
    data_d       = data_q;
    soc_d        = 1'b0;
    cell_sent_d  = 1'b0;
    release_cell = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en && clav_q) begin
          data_d  = mem[cell_addr(rd_ptr_q, OFF_W'(0))];
          soc_d   = 1'b1;
          idx_d   = OFF_W'(1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (!en) begin
          if (idx_q <= LAST) begin
            data_d = mem[cell_addr(rd_ptr_q, idx_q)];
            idx_d  = idx_q + 1'b1;
          end else begin
            release_cell = 1'b1;
            cell_sent_d  = 1'b1;
            rd_ptr_d     = rd_ptr_q + 1'b1;
            if (count_q >= CNT_W'(2)) begin
              data_d = mem[cell_addr(rd_ptr_d, OFF_W'(0))];
              soc_d  = 1'b1;
              idx_d  = OFF_W'(1);
            end else begin
              idx_d   = OFF_W'(0);
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pending commit already claims its slot, so it counts against wr_ready.
  always_comb begin
    count_d    = count_q + CNT_W'(commit_q) - CNT_W'(release_cell);
    clav_d     = count_d > CNT_W'(state_d == SEND);
    wr_ready_d = ({1'b0, count_d} + (CNT_W+1)'(commit_d)) < (CNT_W+1)'(DEPTH);
  end

  // NOTE: cell storage has no reset; contents are only read after a committed write.
  always_ff @(posedge clk_in) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: every flop uses non-blocking assignment so all next-state values land together.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      in_prog_q   <= 1'b0;
      wr_off_q    <= '0;
      wr_ptr_q    <= '0;
      commit_q    <= 1'b0;
      err_drop_q  <= 1'b0;
      wr_ready_q  <= 1'b1;
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      soc_q       <= 1'b0;
      clav_q      <= 1'b0;
      cell_sent_q <= 1'b0;
`ifdef UTOPIA_HEC_GEN_EN
      crc_q       <= 8'h00;
`endif
    end else begin
      in_prog_q   <= in_prog_d;
      wr_off_q    <= wr_off_d;
      wr_ptr_q    <= wr_ptr_d;
      commit_q    <= commit_d;
      err_drop_q  <= err_drop_d;
      wr_ready_q  <= wr_ready_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      soc_q       <= soc_d;
      clav_q      <= clav_d;
      cell_sent_q <= cell_sent_d;
`ifdef UTOPIA_HEC_GEN_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign wr_ready  = wr_ready_q;
  assign data      = data_q;
  assign soc       = soc_q;
  assign clav      = clav_q;
  assign cell_sent = cell_sent_q;
  assign err_drop  = err_drop_q;

endmodule
